// File: rtl/led_debug_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_debug_mux_if
//  Description : Bundles the debug-word inputs, display controls and LED
//                outputs of led_debug_mux. The master side (board glue or
//                testbench) drives the data and controls. The slave side
//                (led_debug_mux) drives the LED, index and frozen outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_debug_mux_if #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int LED_WIDTH  = 8,
    parameter int IDX_W      = 8
);
    logic [CHANNELS*DATA_WIDTH-1:0] dbg_data;
    logic                           manual;
    logic [IDX_W-1:0]               sel_index;
    logic                           freeze;
    logic [LED_WIDTH-1:0]           led;
    logic [IDX_W-1:0]               cur_index;
    logic                           frozen;

    modport master (
        output dbg_data, manual, sel_index, freeze,
        input  led, cur_index, frozen
    );

    modport slave (
        input  dbg_data, manual, sel_index, freeze,
        output led, cur_index, frozen
    );
endinterface
`default_nettype wire

// File: rtl/led_debug_mux.sv
`default_nettype none
// ============================================================================
//  Module      : led_debug_mux
//  Description : LED debug display. Splits CHANNELS debug words into
//                LED_WIDTH-bit segments and shows one segment at a time.
//                The segment is chosen by auto-scan with a DWELL_CYCLES dwell
//                or by manual selection. A rising freeze input latches a
//                coherent snapshot of all channels, and the display uses the
//                snapshot while freeze stays high.
//                Optional build macro LED_DEBUG_HEARTBEAT_EN: the LED MSB
//                shows a heartbeat. The heartbeat toggles every DWELL_CYCLES
//                clocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_debug_mux #(
    parameter int CHANNELS     = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int LED_WIDTH    = 8,
    parameter int DWELL_CYCLES = 25000000,
    parameter int IDX_W        = 8
) (
    input  logic            clk_25mhz,
    input  logic            reset,
    led_debug_mux_if.slave  bus
);

    localparam int c_segs       = DATA_WIDTH / LED_WIDTH;
    localparam int c_segs_total = CHANNELS * c_segs;
    localparam int c_cnt_w      = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0]   c_idx_last   = IDX_W'(c_segs_total - 1);
    localparam logic [IDX_W-1:0]   c_idx_count  = IDX_W'(c_segs_total);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CHANNELS*DATA_WIDTH-1:0] snapshot_q, snapshot_d;
    logic                           freeze_q;
    logic                           frozen_q,   frozen_d;
    logic [c_cnt_w-1:0]             dwell_q,    dwell_d;
    logic [IDX_W-1:0]               cur_index_q, cur_index_d;
    logic [LED_WIDTH-1:0]           led_q,      led_d;

    logic                           capture;
    logic [CHANNELS*DATA_WIDTH-1:0] src;
    logic [LED_WIDTH-1:0]           seg;

`ifdef LED_DEBUG_HEARTBEAT_EN
    logic [c_cnt_w-1:0]             hb_cnt_q,   hb_cnt_d;
    logic                           hb_q,       hb_d;
`endif

    // Snapshot capture on the rising edge of freeze; frozen follows freeze
    // once a capture has happened.
    always_comb begin
        capture    = bus.freeze & ~freeze_q;
        snapshot_d = capture ? bus.dbg_data : snapshot_q;
        frozen_d   = bus.freeze & (capture | frozen_q);
    end

    // Display source: the frozen snapshot or the live debug words.
    always_comb begin
        src = frozen_q ? snapshot_q : bus.dbg_data;
    end

    // Index sequencing. Manual mode copies sel_index and parks the dwell
    // counter at 0. Auto mode advances at the terminal dwell count. An
    // out-of-range index left over from manual mode snaps back to 0.
    always_comb begin
        dwell_d     = dwell_q;
        cur_index_d = cur_index_q;
        if (bus.manual) begin
            dwell_d     = '0;
            cur_index_d = bus.sel_index;
        end else begin
            if (dwell_q == c_dwell_last) begin
                dwell_d = '0;
                if (cur_index_q >= c_idx_last) begin
                    cur_index_d = '0;
                end else begin
                    cur_index_d = cur_index_q + IDX_W'(1);
                end
            end else begin
                dwell_d = dwell_q + c_cnt_w'(1);
                if (cur_index_q >= c_idx_count) begin
                    cur_index_d = '0;
                end
            end
        end
    end

    // Segment select. Channel c segment s sits at bit (c*SEGS+s)*LED_WIDTH
    // of the flattened source, so index i is simply slice i. Indices with
    // no matching slice (out of range) display 0.
    always_comb begin
        seg = '0;
        for (int k = 0; k < c_segs_total; k++) begin
            if (cur_index_q == IDX_W'(k)) begin
                seg = src[k*LED_WIDTH +: LED_WIDTH];
            end
        end
    end

`ifdef LED_DEBUG_HEARTBEAT_EN
    // Free-running heartbeat. It runs in every mode, independent of the
    // scan counter, which parks in manual mode.
    always_comb begin
        hb_d = hb_q;
        if (hb_cnt_q == c_dwell_last) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
        end else begin
            hb_cnt_d = hb_cnt_q + c_cnt_w'(1);
        end
    end

    // LED drive: heartbeat on the MSB, segment data on the rest.
    always_comb begin
        led_d = {hb_q, seg[LED_WIDTH-2:0]};
    end
`else
    // LED drive: full segment data.
    always_comb begin
        led_d = seg;
    end
`endif

    // Register update with synchronous reset taking priority.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            snapshot_q  <= '0;
            freeze_q    <= 1'b0;
            frozen_q    <= 1'b0;
            dwell_q     <= '0;
            cur_index_q <= '0;
            led_q       <= '0;
        end else begin
            snapshot_q  <= snapshot_d;
            freeze_q    <= bus.freeze;
            frozen_q    <= frozen_d;
            dwell_q     <= dwell_d;
            cur_index_q <= cur_index_d;
            led_q       <= led_d;
        end
    end

`ifdef LED_DEBUG_HEARTBEAT_EN
    // Heartbeat registers.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
        end
    end
`endif

    assign bus.led       = led_q;
    assign bus.cur_index = cur_index_q;
    assign bus.frozen    = frozen_q;

endmodule
`default_nettype wire
